// File: rtl/priority_enc_arb.sv
// Registered N_REQ-way priority arbiter with one-hot grant, binary index and valid/ready handshake.
// Define PRIORITY_ENC_RR_EN for round-robin arbitration; otherwise fixed priority, bit 0 highest.
module priority_enc_arb #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [N_REQ-1:0] req_in,
    input  logic             ready_in,
    output logic [N_REQ-1:0] gnt_out,
    output logic [IDX_W-1:0] idx_out,
    output logic             valid_out
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] win;
    logic             accept;
    logic             load;
    int               scan_base;

    // First set bit of req scanning base, base+1, ..., wrapping at N_REQ.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] req,
                                                     input int base);
        logic [IDX_W-1:0] w;
        logic             hit;
        int               k;
        w   = '0;
        hit = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            k = base + j;
            if (k >= N_REQ) k = k - N_REQ;
            if (!hit && req[k[IDX_W-1:0]]) begin
                hit = 1'b1;
                w   = IDX_W'(k);
            end
        end
        return w;
    endfunction

    assign accept = (state_q == HOLD) && ready_in;
    assign load   = (state_q == IDLE) || accept;

`ifdef PRIORITY_ENC_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // On acceptance the new winner already scans from the advanced pointer,
    // so back-to-back grants rotate without repeating the accepted index.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            if (int'(idx_q) == N_REQ - 1) ptr_d = '0;
            else                          ptr_d = IDX_W'(int'(idx_q) + 1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign scan_base = int'(ptr_d);
`else
    assign scan_base = 0;
`endif

    assign win = pick_winner(req_in, scan_base);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        if (load) begin
            if (|req_in) begin
                state_d    = HOLD;
                idx_d      = win;
                gnt_d      = '0;
                gnt_d[win] = 1'b1;
            end else begin
                state_d = IDLE;
                idx_d   = '0;
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt_out   = gnt_q;
    assign idx_out   = idx_q;
    assign valid_out = (state_q == HOLD);

endmodule

// File: tb/tb_priority_enc_arb.sv
// Directed, table-driven bench for priority_enc_arb (fixed mode N_REQ=4; round-robin N_REQ=5
// when PRIORITY_ENC_RR_EN is defined).
module tb_priority_enc_arb;

`ifdef PRIORITY_ENC_RR_EN
    localparam int N = 5;
`else
    localparam int N = 4;
`endif
    localparam int IW = $clog2(N);

    typedef struct packed {
        logic [N-1:0]  req;
        logic          rdy;
        logic          ev;
        logic [N-1:0]  eg;
        logic [IW-1:0] ei;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic          rdy = 1'b0;
    logic [N-1:0]  gnt;
    logic [IW-1:0] idx;
    logic          vld;

    int n_chk  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    priority_enc_arb #(.N_REQ(N)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .req_in   (req),
        .ready_in (rdy),
        .gnt_out  (gnt),
        .idx_out  (idx),
        .valid_out(vld)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic [N-1:0] r, input logic y, input logic v,
                                input logic [N-1:0] g, input int i);
        vec_t e;
        e.req = r;
        e.rdy = y;
        e.ev  = v;
        e.eg  = g;
        e.ei  = IW'(i);
        tbl.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic y, input logic rs);
        req = r;
        rdy = y;
        rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input logic v, input logic [N-1:0] g, input int i);
        check({tag, ".valid"}, 32'(vld), 32'(v));
        check({tag, ".gnt"},   32'(gnt), 32'(g));
        check({tag, ".idx"},   32'(idx), i);
    endtask

    initial begin
        // Reset for two cycles, then idle with no requests.
        step('0, 1'b0, 1'b1);
        expect3("rst0", 1'b0, '0, 0);
        step('0, 1'b1, 1'b1);
        expect3("rst1", 1'b0, '0, 0);
        for (int c = 0; c < 10; c++) begin
            step('0, c[0], 1'b0);
            expect3($sformatf("idle%0d", c), 1'b0, '0, 0);
        end

`ifdef PRIORITY_ENC_RR_EN
        for (int c = 0; c < 7; c++) begin
            add(5'b11111, 1'b1, 1'b1, 5'(1 << (c % 5)), c % 5);
        end
        add(5'b11111, 1'b0, 1'b1, 5'b00010, 1);
        add(5'b11111, 1'b0, 1'b1, 5'b00010, 1);
        add(5'b00001, 1'b1, 1'b1, 5'b00001, 0);
        add(5'b11000, 1'b1, 1'b1, 5'b01000, 3);
        add(5'b00000, 1'b1, 1'b0, 5'b00000, 0);
        add(5'b10001, 1'b1, 1'b1, 5'b10000, 4);
        add(5'b10001, 1'b1, 1'b1, 5'b00001, 0);
        add(5'b00000, 1'b1, 1'b0, 5'b00000, 0);
`else
        add(4'b1010, 1'b1, 1'b1, 4'b0010, 1);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 0);
        add(4'b1111, 1'b0, 1'b1, 4'b0001, 0);
        add(4'b1111, 1'b0, 1'b1, 4'b0001, 0);
        add(4'b1111, 1'b0, 1'b1, 4'b0001, 0);
        add(4'b1000, 1'b0, 1'b1, 4'b0001, 0);
        add(4'b1000, 1'b1, 1'b1, 4'b1000, 3);
        add(4'b0000, 1'b0, 1'b1, 4'b1000, 3);
        add(4'b0001, 1'b0, 1'b1, 4'b1000, 3);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 0);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 0);
        for (int c = 0; c < 4; c++) add(4'b1111, 1'b1, 1'b1, 4'b0001, 0);
        add(4'b0110, 1'b1, 1'b1, 4'b0010, 1);
        add(4'b0100, 1'b1, 1'b1, 4'b0100, 2);
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 0);
`endif

        for (int n = 0; n < tbl.size(); n++) begin
            step(tbl[n].req, tbl[n].rdy, 1'b0);
            expect3($sformatf("vec%0d", n), tbl[n].ev, tbl[n].eg, int'(tbl[n].ei));
        end

        // Stalled grant wiped by reset while ready is high; pointer must restart at 0.
        step(N'(4), 1'b0, 1'b0);
        expect3("rstmid.pend", 1'b1, N'(4), 2);
        step(N'(4), 1'b1, 1'b1);
        expect3("rstmid.rst", 1'b0, '0, 0);
        step('0, 1'b1, 1'b0);
        expect3("rstmid.after", 1'b0, '0, 0);
        step('1, 1'b1, 1'b0);
        expect3("rstmid.ptr0", 1'b1, N'(1), 0);
        step('0, 1'b1, 1'b0);
        expect3("rstmid.drain", 1'b0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
